// File: rtl/time_preset_entry.sv
// -----------------------------------------------------------------------------
// time_preset_entry
//
// Button-driven editor for a two-digit BCD preset (00..MAX_VAL) that is handed
// to a countdown counter with a valid/ready handshake. While editing, the
// selected digit blinks by requesting blanking from the display scanner.
//
// Ports
//   clk           : system clock, all state updates on the rising edge
//   reset         : synchronous, active-high reset
//   btn_inc       : one-cycle pulse, increment the selected digit
//   btn_dec       : one-cycle pulse, decrement the selected digit
//   btn_sel       : one-cycle pulse, enter edit mode / toggle the edited digit
//   btn_ok        : one-cycle pulse, offer the preset to the counter
//   load_ready    : counter accepts the preset this cycle
//   preset_d1/d0  : preset tens/ones digit (BCD, registered)
//   load_valid    : preset offered to the counter (registered)
//   editing       : high while in edit mode
//   edit_digit    : 0 = ones digit selected, 1 = tens digit selected
//   blank_d1/d0   : blank request for the tens/ones digit
// -----------------------------------------------------------------------------
module time_preset_entry #(
    parameter int MAX_D1     = 4,
    parameter int MAX_D0     = 0,
    parameter int INIT_D1    = 4,
    parameter int INIT_D0    = 0,
    parameter int BLINK_HALF = 25000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_inc,
    input  logic       btn_dec,
    input  logic       btn_sel,
    input  logic       btn_ok,
    input  logic       load_ready,
    output logic [3:0] preset_d1,
    output logic [3:0] preset_d0,
    output logic       load_valid,
    output logic       editing,
    output logic       edit_digit,
    output logic       blank_d1,
    output logic       blank_d0
);

    localparam int MAX_VAL = 10 * MAX_D1 + MAX_D0;
    localparam int CW      = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

    typedef enum logic [1:0] {
        IDLE,
        EDIT,
        LOAD
    } state_t;

    state_t        state;
    logic [CW-1:0] blink_cnt;
    logic          blink_phase;
    logic          blink_wrap;
    logic          adjust;
    int            cur_val;
    int            next_val;
    logic [3:0]    next_d1;
    logic [3:0]    next_d0;

    // Exactly one of inc/dec counts as an adjustment; both together cancel.
    assign adjust     = btn_inc ^ btn_dec;
    assign blink_wrap = (blink_cnt == CW'(BLINK_HALF - 1));

    // Adjusted preset, computed in binary and split back into BCD digits.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        cur_val  = int'(preset_d1) * 10 + int'(preset_d0);
        next_val = cur_val;
        if (adjust) begin
            if (!edit_digit) begin
                if (btn_inc) next_val = (cur_val == MAX_VAL) ? 0 : cur_val + 1;
                else         next_val = (cur_val == 0) ? MAX_VAL : cur_val - 1;
            end else begin
                if (btn_inc) next_val = (cur_val + 10 > MAX_VAL) ? 0 : cur_val + 10;
                else         next_val = (cur_val < 10) ? MAX_VAL : cur_val - 10;
            end
        end
        next_d1 = 4'(next_val / 10);
        next_d0 = 4'(next_val % 10);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            preset_d1   <= 4'(INIT_D1);
            preset_d0   <= 4'(INIT_D0);
            load_valid  <= 1'b0;
            editing     <= 1'b0;
            edit_digit  <= 1'b0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    blink_cnt   <= '0;
                    blink_phase <= 1'b0;
                    if (btn_ok) begin
                        state      <= LOAD;
                        load_valid <= 1'b1;
                    end else if (btn_sel) begin
                        state      <= EDIT;
                        editing    <= 1'b1;
                        edit_digit <= 1'b0;
                    end
                end

                EDIT: begin
                    if (btn_ok) begin
                        state       <= LOAD;
                        load_valid  <= 1'b1;
                        editing     <= 1'b0;
                        blink_cnt   <= '0;
                        blink_phase <= 1'b0;
                    end else if (btn_sel) begin
                        edit_digit  <= ~edit_digit;
                        blink_cnt   <= '0;
                        blink_phase <= 1'b0;
                    end else if (adjust) begin
                        preset_d1   <= next_d1;
                        preset_d0   <= next_d0;
                        blink_cnt   <= '0;
                        blink_phase <= 1'b0;
                    end else if (blink_wrap) begin
                        blink_cnt   <= '0;
                        blink_phase <= ~blink_phase;
                    end else begin
                        blink_cnt   <= blink_cnt + 1'b1;
                    end
                end

                LOAD: begin
                    // Preset is frozen and buttons are ignored until accepted.
                    if (load_ready) begin
                        state      <= IDLE;
                        load_valid <= 1'b0;
                    end
                end

                default: begin
                    state      <= IDLE;
                    load_valid <= 1'b0;
                    editing    <= 1'b0;
                end
            endcase
        end
    end

    // Only the selected digit blinks, and only while editing.
    assign blank_d1 = editing &  edit_digit & blink_phase;
    assign blank_d0 = editing & ~edit_digit & blink_phase;

endmodule

// File: tb/tb_time_preset_entry.sv
// -----------------------------------------------------------------------------
// tb_time_preset_entry
//
// Directed bench for time_preset_entry with MAX = 40, INIT = 40 and a short
// blink half-period of 4 cycles. Inputs change on the falling edge and outputs
// are sampled on the falling edge after the rising edge that consumed them.
// -----------------------------------------------------------------------------
module tb_time_preset_entry;

    logic       clk;
    logic       reset;
    logic       btn_inc;
    logic       btn_dec;
    logic       btn_sel;
    logic       btn_ok;
    logic       load_ready;
    logic [3:0] preset_d1;
    logic [3:0] preset_d0;
    logic       load_valid;
    logic       editing;
    logic       edit_digit;
    logic       blank_d1;
    logic       blank_d0;

    int total = 0;
    int bad   = 0;

    time_preset_entry #(
        .MAX_D1    (4),
        .MAX_D0    (0),
        .INIT_D1   (4),
        .INIT_D0   (0),
        .BLINK_HALF(4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_inc   (btn_inc),
        .btn_dec   (btn_dec),
        .btn_sel   (btn_sel),
        .btn_ok    (btn_ok),
        .load_ready(load_ready),
        .preset_d1 (preset_d1),
        .preset_d0 (preset_d0),
        .load_valid(load_valid),
        .editing   (editing),
        .edit_digit(edit_digit),
        .blank_d1  (blank_d1),
        .blank_d0  (blank_d0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drive one cycle of button pulses, then return on the next falling edge
    // with all buttons released.
    task automatic step(input logic inc, input logic dec, input logic sel, input logic ok);
        btn_inc = inc;
        btn_dec = dec;
        btn_sel = sel;
        btn_ok  = ok;
        @(negedge clk);
        btn_inc = 1'b0;
        btn_dec = 1'b0;
        btn_sel = 1'b0;
        btn_ok  = 1'b0;
    endtask

    task automatic check_val(input string tag, input int exp);
        check(tag, 32'(int'(preset_d1) * 10 + int'(preset_d0)), 32'(exp));
    endtask

    initial begin
        reset      = 1'b1;
        btn_inc    = 1'b0;
        btn_dec    = 1'b0;
        btn_sel    = 1'b0;
        btn_ok     = 1'b0;
        load_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Reset state
        check("rst_d1", 32'(preset_d1), 32'd4);
        check("rst_d0", 32'(preset_d0), 32'd0);
        check("rst_valid", 32'(load_valid), 32'd0);
        check("rst_editing", 32'(editing), 32'd0);
        check("rst_digit", 32'(edit_digit), 32'd0);
        check("rst_blank", 32'({blank_d1, blank_d0}), 32'd0);

        // IDLE ignores inc/dec; stray load_ready does nothing
        step(1, 0, 0, 0);
        check_val("idle_inc", 40);
        check("idle_inc_edit", 32'(editing), 32'd0);
        load_ready = 1'b1;
        step(0, 0, 0, 0);
        check("stray_ready", 32'(load_valid), 32'd0);
        load_ready = 1'b0;

        // Commit from IDLE: valid for exactly one cycle
        step(0, 0, 0, 1);
        check("ok_valid", 32'(load_valid), 32'd1);
        check_val("ok_val", 40);
        load_ready = 1'b1;
        step(0, 0, 0, 0);
        check("ok_accept", 32'(load_valid), 32'd0);
        load_ready = 1'b0;
        step(0, 0, 0, 0);
        check("ok_idle", 32'(load_valid), 32'd0);

        // Enter EDIT, ones digit: 40 wraps to 00, then 01, 02
        step(0, 0, 1, 0);
        check("sel_edit", 32'(editing), 32'd1);
        check("sel_digit", 32'(edit_digit), 32'd0);
        check("sel_blank", 32'({blank_d1, blank_d0}), 32'd0);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0);
        check_val("ones_inc3", 2);

        // Tens digit: 02 -> 12 -> 22 -> 32 -> 00 (42 > 40)
        step(0, 0, 1, 0);
        check("sel_tens", 32'(edit_digit), 32'd1);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0);
        check_val("tens_inc3", 32);
        step(1, 0, 0, 0);
        check_val("tens_inc_ovf", 0);

        // Tens dec at 00 -> 40, then 30, 20, 10, 00
        step(0, 1, 0, 0);
        check_val("tens_dec_wrap", 40);
        for (int i = 0; i < 4; i++) step(0, 1, 0, 0);
        check_val("tens_dec4", 0);

        // Ones dec at 00 -> 40
        step(0, 0, 1, 0);
        step(0, 1, 0, 0);
        check_val("ones_dec_wrap", 40);

        // Build 05, tens dec -> 40
        step(1, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0);
        check_val("ones_to5", 5);
        step(0, 0, 1, 0);
        step(0, 1, 0, 0);
        check_val("tens_dec_low", 40);

        // Blink of tens digit: 4 cycles visible, then 4 blanked
        for (int k = 0; k < 6; k++) begin
            check($sformatf("blink_d1_%0d", k), 32'(blank_d1), (k >= 4) ? 32'd1 : 32'd0);
            check($sformatf("blink_d0_%0d", k), 32'(blank_d0), 32'd0);
            step(0, 0, 0, 0);
        end
        // Accepted button clears the phase and restarts a full half-period
        step(1, 0, 0, 0);
        check_val("blink_inc_val", 0);
        for (int j = 0; j < 5; j++) begin
            check($sformatf("reblink_d1_%0d", j), 32'(blank_d1), (j >= 4) ? 32'd1 : 32'd0);
            step(0, 0, 0, 0);
        end

        // Simultaneous inc+dec leaves the value alone
        step(1, 0, 0, 0);
        check_val("pre_both", 10);
        step(1, 1, 0, 0);
        check_val("inc_dec_both", 10);

        // LOAD held while counter not ready; buttons ignored
        step(0, 0, 0, 1);
        check("load_valid", 32'(load_valid), 32'd1);
        check("load_editing", 32'(editing), 32'd0);
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 0, 0);
            check_val($sformatf("load_hold_%0d", i), 10);
            check($sformatf("load_hold_v_%0d", i), 32'(load_valid), 32'd1);
        end
        load_ready = 1'b1;
        step(0, 0, 0, 0);
        check("load_accept", 32'(load_valid), 32'd0);
        load_ready = 1'b0;

        // ok beats sel in EDIT
        step(0, 0, 1, 0);
        check("re_edit", 32'(editing), 32'd1);
        step(0, 0, 1, 1);
        check("ok_sel_valid", 32'(load_valid), 32'd1);
        check("ok_sel_editing", 32'(editing), 32'd0);

        // Reset mid-LOAD abandons the offer and restores INIT
        reset = 1'b1;
        step(1, 0, 1, 1);
        reset = 1'b0;
        check("rst_load_valid", 32'(load_valid), 32'd0);
        check_val("rst_load_val", 40);
        check("rst_load_edit", 32'(editing), 32'd0);
        step(0, 0, 0, 0);
        check("rst_load_idle", 32'(load_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
